// File: rtl/nonrestoring_divider.sv
// Sequential signed divider using the non-restoring algorithm: one quotient
// bit per cycle, then a single correction/sign-fix cycle before results load.
module nonrestoring_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         dbz,
  output logic         ovf
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [N-1:0]  MOST_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]  ALL_ONES = {N{1'b1}};

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t        state_q, state_d;
  logic [N:0]    a_q, a_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sign_q_q, sign_q_d;
  logic          sign_r_q, sign_r_d;
  logic          ovf_pend_q, ovf_pend_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;
  logic [N-1:0]  quotient_q, quotient_d;
  logic [N-1:0]  remainder_q, remainder_d;

  logic [N-1:0]  dividend_mag, divisor_mag;
  logic [N:0]    m_ext, a_shift, a_step, a_fix;

  // Magnitudes stay N-bit unsigned so the most-negative value maps to 2^(N-1).
  assign dividend_mag = dividend[N-1] ? -dividend : dividend;
  assign divisor_mag  = divisor[N-1]  ? -divisor  : divisor;

  assign m_ext   = {1'b0, m_q};
  assign a_shift = {a_q[N-1:0], q_q[N-1]};
  assign a_step  = a_q[N] ? (a_shift + m_ext) : (a_shift - m_ext);
  assign a_fix   = a_q[N] ? (a_q + m_ext) : a_q;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    q_d         = q_q;
    m_d         = m_q;
    cnt_d       = cnt_q;
    sign_q_d    = sign_q_q;
    sign_r_d    = sign_r_q;
    ovf_pend_d  = ovf_pend_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          if (divisor == '0) begin
            quotient_d  = ALL_ONES;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end else begin
            q_d        = dividend_mag;
            m_d        = divisor_mag;
            a_d        = '0;
            sign_q_d   = dividend[N-1] ^ divisor[N-1];
            sign_r_d   = dividend[N-1];
            ovf_pend_d = (dividend == MOST_NEG) && (divisor == ALL_ONES);
            cnt_d      = CNT_INIT;
            state_d    = ITER;
          end
        end
      end
      ITER: begin
        a_d = a_step;
        q_d = {q_q[N-2:0], ~a_step[N]};
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      FIX: begin
        a_d         = a_fix;
        quotient_d  = sign_q_q ? -q_q : q_q;
        remainder_d = sign_r_q ? -a_fix[N-1:0] : a_fix[N-1:0];
        ovf_d       = ovf_pend_q;
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags follow the state being entered so they are registered outputs.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      cnt_q       <= '0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      ovf_pend_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      m_q         <= m_d;
      cnt_q       <= cnt_d;
      sign_q_q    <= sign_q_d;
      sign_r_q    <= sign_r_d;
      ovf_pend_q  <= ovf_pend_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Directed and randomized checks of the 8-bit non-restoring divider:
// results, latency, flags, reset abort and start handling while busy.
module tb_nonrestoring_divider;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       dbz;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  nonrestoring_divider #(.N(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Returns the number of edges (counted from the current negedge) until done is seen, or -1.
  task automatic waitDone(output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Latency is counted in edges after the start edge; called at a negedge.
  task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] expQ, input logic [7:0] expR,
                               input logic expDbz, input logic expOvf, input int expLat);
    int lat;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, "_busy"}, 32'(busy), 32'(1));
    waitDone(lat);
    checkOutput({tag, "_lat"}, lat, expLat);
    checkOutput({tag, "_res"}, 32'({quotient, remainder, dbz, ovf}),
                32'({expQ, expR, expDbz, expOvf}));
    @(negedge clk);
    checkOutput({tag, "_hold"}, 32'({done, busy, quotient, remainder, dbz, ovf}),
                32'({1'b0, 1'b0, expQ, expR, expDbz, expOvf}));
  endtask

  function automatic logic [17:0] refDiv(input logic [7:0] a, input logic [7:0] b);
    int sa;
    int sb;
    logic [7:0] q;
    logic [7:0] r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (b == 8'h00) return {8'hFF, a, 2'b10};
    if (a == 8'h80 && b == 8'hFF) return {8'h80, 8'h00, 2'b01};
    q = 8'(sa / sb);
    r = 8'(sa % sb);
    return {q, r, 2'b00};
  endfunction

  task automatic sweepOne(input logic [7:0] a, input logic [7:0] b);
    logic [17:0] e;
    e = refDiv(a, b);
    applyStimulus("sweep", a, b, e[17:10], e[9:2], e[1], e[0], e[1] ? 0 : 9);
  endtask

  initial begin
    int lat;
    logic [7:0] edgeVals [7];
    edgeVals = '{8'h00, 8'h01, 8'hFF, 8'h7F, 8'h80, 8'h02, 8'hFE};

    reset    = 1'b1;
    start    = 1'b0;
    dividend = 8'h00;
    divisor  = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("reset_outs", 32'({busy, done, dbz, ovf, quotient, remainder}), 32'(0));
    reset = 1'b0;

    applyStimulus("p100_d7",   8'd100, 8'd7,  8'd14,  8'd2,  1'b0, 1'b0, 9);
    applyStimulus("m100_d7",   8'h9C,  8'd7,  8'hF2,  8'hFE, 1'b0, 1'b0, 9);
    applyStimulus("p100_dm7",  8'd100, 8'hF9, 8'hF2,  8'h02, 1'b0, 1'b0, 9);
    applyStimulus("ovf",       8'h80,  8'hFF, 8'h80,  8'h00, 1'b0, 1'b1, 9);
    applyStimulus("neg_div1",  8'h80,  8'h01, 8'h80,  8'h00, 1'b0, 1'b0, 9);
    applyStimulus("dbz",       8'd55,  8'h00, 8'hFF,  8'h37, 1'b1, 1'b0, 0);
    applyStimulus("after_dbz", 8'd100, 8'd7,  8'd14,  8'd2,  1'b0, 1'b0, 9);

    // Abort mid-iteration with reset, then start on the first edge after it clears.
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_outs", 32'({busy, done, dbz, ovf, quotient, remainder}), 32'(0));
    reset = 1'b0;
    applyStimulus("after_abort", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 1'b0, 9);

    // Start pulse and operand churn while busy must not disturb the running divide.
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'hAA;
    divisor  = 8'h03;
    waitDone(lat);
    checkOutput("busy_start_lat", lat, 5);
    checkOutput("busy_start_res", 32'({quotient, remainder, ovf, dbz}), 32'({8'd14, 8'd2, 2'b00}));
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(negedge clk);
    checkOutput("held_start_idle", 32'({busy, done}), 32'(0));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("held_start_busy", 32'(busy), 32'(1));
    waitDone(lat);
    checkOutput("held_start_lat", lat, 9);
    checkOutput("held_start_res", 32'({quotient, remainder}), 32'({8'd10, 8'd0}));
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 7; j++) begin
        sweepOne(edgeVals[i], edgeVals[j]);
      end
    end
    for (int k = 0; k < 150; k++) begin
      sweepOne(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
